// File: rtl/pe_pkg.sv
// Shared definitions for the systolic processing element: default widths,
// operand extension helper, saturation limits and the forwarded flag bundle.
package pe_pkg;

    localparam int unsigned PE_DATA_W = 16;
    localparam int unsigned PE_ACC_W  = 40;
    // Widest vector the helper functions handle
    localparam int unsigned PE_MAX_W  = 128;

    // Operand qualifiers travelling with the west operand
    typedef struct packed {
        logic vld;
        logic first;
        logic last;
    } pe_flags_t;

    // Extend the low w bits of v to PE_MAX_W, sign- or zero-filling above
    function automatic logic [PE_MAX_W-1:0] pe_extend(
        input logic [PE_MAX_W-1:0] v,
        input int unsigned         w,
        input logic                is_signed
    );
        logic [PE_MAX_W-1:0] mask;
        logic [PE_MAX_W-1:0] top;
        mask = (PE_MAX_W'(1) << w) - PE_MAX_W'(1);
        top  = v >> (w - 32'd1);
        return (is_signed && top[0]) ? (v | ~mask) : (v & mask);
    endfunction

    // Largest value representable in w bits
    function automatic logic [PE_MAX_W-1:0] pe_sat_max(
        input int unsigned w,
        input logic        is_signed
    );
        logic [PE_MAX_W-1:0] mask;
        mask = (PE_MAX_W'(1) << w) - PE_MAX_W'(1);
        return is_signed ? (mask >> 1) : mask;
    endfunction

    // Smallest value representable in w bits
    function automatic logic [PE_MAX_W-1:0] pe_sat_min(
        input int unsigned w,
        input logic        is_signed
    );
        return is_signed ? (PE_MAX_W'(1) << (w - 32'd1)) : '0;
    endfunction

endpackage

// File: rtl/pe_mul_stage.sv
// Registered DATA_W x DATA_W multiplier (product stage of the PE).
// Full-width product, signed or unsigned per SIGNED.
module pe_mul_stage #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned SIGNED = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic [2*DATA_W-1:0]   prod
);

    localparam int unsigned PROD_W = 2 * DATA_W;

    logic [PROD_W-1:0] a_x;
    logic [PROD_W-1:0] b_x;
    logic [PROD_W-1:0] prod_c;

    // Extend both operands to product width; low PROD_W bits are exact either way
    always_comb begin
        a_x    = {{DATA_W{(SIGNED != 0) & a[DATA_W-1]}}, a};
        b_x    = {{DATA_W{(SIGNED != 0) & b[DATA_W-1]}}, b};
        prod_c = a_x * b_x;
    end

    // Product register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prod <= '0;
        end else if (en) begin
            prod <= prod_c;
        end
    end

endmodule

// File: rtl/pe_mac_cell.sv
// Systolic-array processing element: captures north/west operands, forwards
// them south/east one cycle later, multiplies, and accumulates per tile,
// draining each tile sum on a one-cycle out_vld pulse.
// Optional build macro PE_SATURATE_EN: clamp the accumulator instead of wrapping.
module pe_mac_cell
    import pe_pkg::*;
#(
    parameter int unsigned DATA_W = PE_DATA_W,
    parameter int unsigned ACC_W  = PE_ACC_W,
    parameter int unsigned SIGNED = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [DATA_W-1:0] in_N,
    input  logic              in_N_vld,
    input  logic [DATA_W-1:0] in_W,
    input  logic              in_W_vld,
    input  logic              in_W_first,
    input  logic              in_W_last,
    output logic [DATA_W-1:0] out_S,
    output logic              out_S_vld,
    output logic [DATA_W-1:0] out_E,
    output logic              out_E_vld,
    output logic              out_E_first,
    output logic              out_E_last,
    output logic [ACC_W-1:0]  out,
    output logic              out_vld,
    output logic              err,
    output logic              sat
);

    localparam int unsigned PROD_W = 2 * DATA_W;

    if (ACC_W < PROD_W) begin : g_acc_w_check
        $error("pe_mac_cell: ACC_W must be >= 2*DATA_W");
    end

    logic [DATA_W-1:0] rin_N;
    logic [DATA_W-1:0] rin_W;
    logic              rin_N_vld;
    pe_flags_t         rin_W_f;
    pe_flags_t         s1_f;
    logic [PROD_W-1:0] prod;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  prod_x;
    logic [ACC_W-1:0]  acc_next_c;

    // S0: operand capture; also the south/east forwarding registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rin_N     <= '0;
            rin_W     <= '0;
            rin_N_vld <= 1'b0;
            rin_W_f   <= '0;
        end else if (en) begin
            rin_N     <= in_N;
            rin_W     <= in_W;
            rin_N_vld <= in_N_vld;
            rin_W_f   <= {in_W_vld, in_W_first, in_W_last};
        end
    end

    assign out_S       = rin_N;
    assign out_S_vld   = rin_N_vld;
    assign out_E       = rin_W;
    assign out_E_vld   = rin_W_f.vld;
    assign out_E_first = rin_W_f.first;
    assign out_E_last  = rin_W_f.last;

    // S1: product
    pe_mul_stage #(
        .DATA_W (DATA_W),
        .SIGNED (SIGNED)
    ) u_mul (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .a     (rin_N),
        .b     (rin_W),
        .prod  (prod)
    );

    // S1: fire/first/last alongside the product; sticky valid-mismatch error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_f <= '0;
            err  <= 1'b0;
        end else if (en) begin
            s1_f <= {rin_N_vld & rin_W_f.vld, rin_W_f.first, rin_W_f.last};
            err  <= err | (rin_N_vld ^ rin_W_f.vld);
        end
    end

`ifdef PE_SATURATE_EN
    localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'(pe_sat_max(ACC_W, SIGNED != 0));
    localparam logic [ACC_W-1:0] SAT_MIN = ACC_W'(pe_sat_min(ACC_W, SIGNED != 0));

    logic [ACC_W:0] sum_c;
    logic           clamp_c;

    // Next accumulator value with overflow clamping
    always_comb begin
        prod_x     = ACC_W'(pe_extend(PE_MAX_W'(prod), PROD_W, SIGNED != 0));
        sum_c      = {1'b0, acc} + {1'b0, prod_x};
        acc_next_c = s1_f.first ? prod_x : sum_c[ACC_W-1:0];
        clamp_c    = 1'b0;
        if (!s1_f.first) begin
            if (SIGNED != 0) begin
                if ((acc[ACC_W-1] == prod_x[ACC_W-1]) && (sum_c[ACC_W-1] != acc[ACC_W-1])) begin
                    clamp_c    = 1'b1;
                    acc_next_c = acc[ACC_W-1] ? SAT_MIN : SAT_MAX;
                end
            end else if (sum_c[ACC_W]) begin
                clamp_c    = 1'b1;
                acc_next_c = SAT_MAX;
            end
        end
    end

    // Sticky clamp flag, only on accumulating cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat <= 1'b0;
        end else if (en && s1_f.vld && clamp_c) begin
            sat <= 1'b1;
        end
    end
`else
    logic [ACC_W-1:0] sum_c;

    // Next accumulator value, modulo 2^ACC_W
    always_comb begin
        prod_x     = ACC_W'(pe_extend(PE_MAX_W'(prod), PROD_W, SIGNED != 0));
        sum_c      = acc + prod_x;
        acc_next_c = s1_f.first ? prod_x : sum_c;
    end

    assign sat = 1'b0;
`endif

    // S2: accumulate, drain on last, pulse out_vld
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc     <= '0;
            out     <= '0;
            out_vld <= 1'b0;
        end else if (en) begin
            out_vld <= 1'b0;
            if (s1_f.vld) begin
                if (s1_f.last) begin
                    out     <= acc_next_c;
                    out_vld <= 1'b1;
                    acc     <= '0;
                end else begin
                    acc <= acc_next_c;
                end
            end
        end
    end

endmodule
